// File: rtl/pipo_arb_pkg.sv
// Shared types, default sizing and helpers for the round-robin PIPO load arbiter.
package pipo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pipo_state_e;

  localparam int PIPO_WIDTH       = 4;
  localparam int PIPO_NUM_REQ     = 4;
  localparam int PIPO_HOLD_CYCLES = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// Requester-side request/data bundle and shared-register outputs of the arbiter.
interface pipo_load_arbiter_if
  import pipo_arb_pkg::*;
#(
  parameter int NUM_REQ = PIPO_NUM_REQ,
  parameter int WIDTH   = PIPO_WIDTH
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         parallel_out;
  logic [ID_W-1:0]          owner;
  logic                     out_valid;
  logic                     busy;

  modport master (
    output req, req_data,
    input  grant, parallel_out, owner, out_valid, busy
  );

  modport slave (
    input  req, req_data,
    output grant, parallel_out, owner, out_valid, busy
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first eligible requester scanning upward
// from the pointer with wrap.
module rr_priority_pick
  import pipo_arb_pkg::*;
#(
  parameter int NUM_REQ = PIPO_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    pointer,
  output logic               any_valid,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    winner_idx
);

  logic [NUM_REQ-1:0] eligible_s;
  logic [ID_W-1:0]    scan_s;

  assign eligible_s = req & ~mask;

  // Walk every position once, starting at the pointer, keeping the first hit.
  always_comb begin
    any_valid  = 1'b0;
    winner     = '0;
    winner_idx = '0;
    scan_s     = pointer;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (eligible_s[scan_s] && !any_valid) begin
        any_valid  = 1'b1;
        winner_idx = scan_s;
      end else begin
        any_valid  = any_valid;
      end
      if (scan_s == ID_W'(NUM_REQ - 1)) begin
        scan_s = '0;
      end else begin
        scan_s = scan_s + ID_W'(1);
      end
    end
    if (any_valid) begin
      winner[winner_idx] = 1'b1;
    end else begin
      winner = '0;
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Shared parallel register loaded round-robin from NUM_REQ requesters, held
// stable for HOLD_CYCLES cycles after every load.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int NUM_REQ     = PIPO_NUM_REQ,
  parameter int WIDTH       = PIPO_WIDTH,
  parameter int HOLD_CYCLES = PIPO_HOLD_CYCLES
) (
  input logic               clk,
  input logic               rst,
  pipo_load_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);

  pipo_state_e        state_r, state_nx;
  logic [3:0]         cnt_r, cnt_nx;
  logic [ID_W-1:0]    ptr_r, ptr_nx;
  logic [WIDTH-1:0]   data_r, data_nx;
  logic [NUM_REQ-1:0] grant_r, grant_nx;
  logic [ID_W-1:0]    owner_r, owner_nx;
  logic               valid_r, valid_nx;
  logic               busy_r;

  logic               pick_any_s;
  logic [NUM_REQ-1:0] pick_oh_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic [WIDTH-1:0]   word_s;

  // The grant being shown this cycle masks its own requester from re-winning.
  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (bus.req),
    .mask       (grant_r),
    .pointer    (ptr_r),
    .any_valid  (pick_any_s),
    .winner     (pick_oh_s),
    .winner_idx (pick_idx_s)
  );

  assign word_s = bus.req_data[int'(pick_idx_s)*WIDTH +: WIDTH];

  // Next-state, load and pointer-advance decisions.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    ptr_nx   = ptr_r;
    data_nx  = data_r;
    grant_nx = '0;
    owner_nx = owner_r;
    valid_nx = valid_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          data_nx  = word_s;
          owner_nx = pick_idx_s;
          valid_nx = 1'b1;
          grant_nx = pick_oh_s;
          ptr_nx   = (pick_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + ID_W'(1);
          if (HOLD_CYCLES > 0) begin
            state_nx = HOLD;
            cnt_nx   = 4'(HOLD_CYCLES - 1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end
        end else begin
          grant_nx = '0;
        end
      end
      HOLD: begin
        if (cnt_r == 4'd0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset aborts a hold immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ptr_r   <= '0;
      data_r  <= '0;
      grant_r <= '0;
      owner_r <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      ptr_r   <= ptr_nx;
      data_r  <= data_nx;
      grant_r <= grant_nx;
      owner_r <= owner_nx;
      valid_r <= valid_nx;
      busy_r  <= (state_nx == HOLD);
    end
  end

  assign bus.grant        = grant_r;
  assign bus.parallel_out = data_r;
  assign bus.owner        = owner_r;
  assign bus.out_valid    = valid_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench: a HOLD_CYCLES=2 instance (a) and a HOLD_CYCLES=0 instance (b).
module tb_pipo_load_arbiter;

  typedef struct {
    int cyc;
    int grant;
    int data;
    int owner;
    int busy;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   hold_data_a = 0, hold_owner_a = 0;
  int   hold_data_b = 0, hold_owner_b = 0;

  pipo_load_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) a ();
  pipo_load_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) b ();

  pipo_load_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  pipo_load_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for instance a: reset state, scoreboard on grant, hold otherwise.
  always @(negedge clk) begin
    if (cyc != 0) begin
      if (rst_q) begin
        check("a_rst_grant", 32'(a.grant), 32'd0);
        check("a_rst_data", 32'(a.parallel_out), 32'd0);
        check("a_rst_owner", 32'(a.owner), 32'd0);
        check("a_rst_valid", 32'(a.out_valid), 32'd0);
        check("a_rst_busy", 32'(a.busy), 32'd0);
        hold_data_a  = 0;
        hold_owner_a = 0;
      end else if (a.grant != 4'd0) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_grant", 32'(a.grant), 32'd0);
        end else begin
          e_a = q_a.pop_front();
          check("a_load_cycle", cyc, e_a.cyc);
          check("a_grant", 32'(a.grant), e_a.grant);
          check("a_data", 32'(a.parallel_out), e_a.data);
          check("a_owner", 32'(a.owner), e_a.owner);
          check("a_valid", 32'(a.out_valid), 32'd1);
          check("a_busy", 32'(a.busy), e_a.busy);
          hold_data_a  = e_a.data;
          hold_owner_a = e_a.owner;
        end
      end else begin
        check("a_hold_data", 32'(a.parallel_out), hold_data_a);
        check("a_hold_owner", 32'(a.owner), hold_owner_a);
      end
    end
  end

  // Monitor for instance b; with no hold phase busy must never rise.
  always @(negedge clk) begin
    if (cyc != 0) begin
      if (rst_q) begin
        check("b_rst_grant", 32'(b.grant), 32'd0);
        check("b_rst_data", 32'(b.parallel_out), 32'd0);
        check("b_rst_valid", 32'(b.out_valid), 32'd0);
        hold_data_b  = 0;
        hold_owner_b = 0;
      end else if (b.grant != 4'd0) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_grant", 32'(b.grant), 32'd0);
        end else begin
          e_b = q_b.pop_front();
          check("b_load_cycle", cyc, e_b.cyc);
          check("b_grant", 32'(b.grant), e_b.grant);
          check("b_data", 32'(b.parallel_out), e_b.data);
          check("b_owner", 32'(b.owner), e_b.owner);
          check("b_busy", 32'(b.busy), e_b.busy);
          hold_data_b  = e_b.data;
          hold_owner_b = e_b.owner;
        end
      end else begin
        check("b_hold_data", 32'(b.parallel_out), hold_data_b);
        check("b_hold_owner", 32'(b.owner), hold_owner_b);
        check("b_busy_idle", 32'(b.busy), 32'd0);
      end
    end
  end

  task automatic push_a(input int c, input int g, input int d, input int o);
    q_a.push_back('{cyc: c, grant: g, data: d, owner: o, busy: 1});
  endtask

  task automatic push_b(input int c, input int g, input int d, input int o);
    q_b.push_back('{cyc: c, grant: g, data: d, owner: o, busy: 0});
  endtask

  initial begin
    int q0;
    rst        = 1'b1;
    a.req      = 4'b1111;
    a.req_data = {4'b0100, 4'b0011, 4'b0010, 4'b0001};
    b.req      = 4'b0000;
    b.req_data = 16'h0000;

    // Reset with all requests high, then release: loads 0,1,2,3 three cycles apart.
    push_a(3, 4'b0001, 4'b0001, 0);
    push_a(6, 4'b0010, 4'b0010, 1);
    push_a(9, 4'b0100, 4'b0011, 2);
    push_a(12, 4'b1000, 4'b0100, 3);
    tick(2);
    rst = 1'b0;
    tick(10);
    a.req = 4'b0000;

    // Single requester 2, busy for exactly two cycles.
    tick(4);
    push_a(17, 4'b0100, 4'b1010, 2);
    a.req_data[8 +: 4] = 4'b1010;
    a.req = 4'b0100;
    tick(1);
    a.req = 4'b0000;
    tick(1);
    check("a_busy_hold2", 32'(a.busy), 32'd1);
    tick(1);
    check("a_busy_idle", 32'(a.busy), 32'd0);

    // Requesters 0 and 3 both held: pointer sits at 3, so they alternate 3,0,3,0.
    push_a(20, 4'b1000, 4'b0100, 3);
    push_a(23, 4'b0001, 4'b0001, 0);
    push_a(26, 4'b1000, 4'b0100, 3);
    push_a(29, 4'b0001, 4'b0001, 0);
    a.req = 4'b1001;
    tick(10);
    a.req = 4'b0000;

    // Grant requester 1, reset in its second hold cycle, then requesters 1 and 3.
    tick(2);
    push_a(32, 4'b0010, 4'b0010, 1);
    a.req = 4'b0010;
    tick(1);
    a.req = 4'b0000;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    push_a(35, 4'b0010, 4'b0010, 1);
    push_a(38, 4'b1000, 4'b0100, 3);
    a.req = 4'b1010;
    tick(1);
    a.req = 4'b1000;
    tick(3);
    a.req = 4'b0000;
    tick(2);

    // Zero-hold instance: lingering req[1] loads every other cycle, new word each time.
    q0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push_b(q0 + 1 + 2 * i, 4'b0010, (i % 2 == 0) ? 4'b1100 : 4'b0011, 1);
    end
    b.req_data[4 +: 4] = 4'b1100;
    b.req = 4'b0010;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        b.req = 4'b0000;
      end else begin
        b.req_data[4 +: 4] = (i % 2 == 0) ? 4'b0011 : 4'b1100;
      end
      tick(2);
    end

    tick(3);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
